// File: rtl/div_pkg.sv
// Shared types and sizing for the sequential divider family.
// The iteration counter is sized from DIV_W so it can address every quotient bit.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    localparam int DIV_W = 16;
    localparam int CNT_W = $clog2(DIV_W);

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division trial step: subtracts the zero-extended divisor from the
// shifted partial remainder as P' + ~{0,B} + 1; the carry-out is the quotient bit.
module div_sub_stage #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH:0]   p_shift,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   diff,
    output logic             no_borrow
);

    logic [WIDTH+1:0] sum_s;

    // Trial subtraction with an explicit carry column so no_borrow falls out of the MSB
    always_comb begin
        sum_s = '0;
        sum_s = {1'b0, p_shift} + {1'b0, ~{1'b0, divisor}} + {{(WIDTH + 1){1'b0}}, 1'b1};
    end

    assign diff      = sum_s[WIDTH:0];
    assign no_borrow = sum_s[WIDTH + 1];

endmodule

// File: rtl/seq_div_16bit.sv
// Iterative unsigned divider producing one quotient bit per clock behind a
// start/busy/done handshake; results are only published on entry to DONE.
module seq_div_16bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       state_r;
    logic [CNT_W-1:0] count_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH:0]   p_r;
    logic [WIDTH:0]   p_shift_s;
    logic [WIDTH:0]   diff_s;
    logic [WIDTH:0]   p_next_s;
    logic             no_borrow_s;

    // a_r doubles as the quotient register: dividend bits leave at the top while quotient bits enter at the bottom
    assign p_shift_s = {p_r[WIDTH-1:0], a_r[WIDTH-1]};
    assign p_next_s  = no_borrow_s ? diff_s : p_shift_s;

    div_sub_stage #(
        .WIDTH(WIDTH)
    ) u_sub (
        .p_shift  (p_shift_s),
        .divisor  (b_r),
        .diff     (diff_s),
        .no_borrow(no_borrow_s)
    );

    // Control FSM, iteration counter, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            count_r     <= '0;
            a_r         <= '0;
            b_r         <= '0;
            p_r         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (divisor == '0) begin
                            state_r     <= DONE;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                        end else begin
                            state_r     <= RUN;
                            a_r         <= dividend;
                            b_r         <= divisor;
                            p_r         <= '0;
                            count_r     <= '0;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    a_r <= {a_r[WIDTH-2:0], no_borrow_s};
                    p_r <= p_next_s;
                    if (count_r == CNT_LAST) begin
                        state_r   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        quotient  <= {a_r[WIDTH-2:0], no_borrow_s};
                        remainder <= p_next_s[WIDTH-1:0];
                    end else begin
                        count_r <= count_r + {{(CNT_W - 1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_16bit.sv
// Scoreboard bench for seq_div_16bit: expected results are queued when a start is
// accepted and compared against the outputs when done pulses.
module tb_seq_div_16bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic [15:0] r;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    seq_div_16bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.dz = (b == 16'd0);
        e.q  = e.dz ? 16'hFFFF : a / b;
        e.r  = e.dz ? a : a % b;
        return e;
    endfunction

    task automatic check_result();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            if (quotient !== e.q || remainder !== e.r)
                $display("operands a=%0d b=%0d", e.a, e.b);
            chk("quotient", {16'd0, quotient}, {16'd0, e.q});
            chk("remainder", {16'd0, remainder}, {16'd0, e.r});
            chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
        end
    endtask

    // Assumes start was raised before the upcoming accept edge; cycles count from that edge
    task automatic wait_done(input int exp_lat, input int exp_busy, input int inject_at);
        int cyc;
        int bcyc;
        bit seen;
        cyc  = 0;
        bcyc = 0;
        seen = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (busy) bcyc++;
            if (done) seen = 1;
            if (cyc == inject_at) begin
                dividend = 16'd9;
                divisor  = 16'd2;
                start    = 1'b1;
            end
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        chk("latency", cyc, exp_lat);
        chk("busy_cycles", bcyc, exp_busy);
        check_result();
    endtask

    task automatic do_op(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] q_hold;
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(model(a, b));
        if (b == 16'd0) wait_done(1, 0, 0);
        else            wait_done(17, 16, 0);
        q_hold = quotient;
        @(posedge clk);
        #1;
        chk("done_pulse", {31'd0, done}, 32'd0);
        chk("q_held", {16'd0, quotient}, {16'd0, q_hold});
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 16'd0;
        divisor  = 16'd0;
        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", {16'd0, quotient}, 32'd0);
        chk("rst_r", {16'd0, remainder}, 32'd0);
        chk("rst_dz", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(16'd100, 16'd7);
        do_op(16'hFFFF, 16'd1);
        do_op(16'd3, 16'd10);
        do_op(16'd0, 16'd5);
        do_op(16'h8000, 16'h8000);
        do_op(16'd5, 16'd0);
        do_op(16'd77, 16'd77);

        // Ignored mid-run start, then a back-to-back start in the DONE cycle
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        sb.push_back(model(16'd100, 16'd7));
        wait_done(17, 16, 5);
        dividend = 16'd9;
        divisor  = 16'd2;
        start    = 1'b1;
        sb.push_back(model(16'd9, 16'd2));
        wait_done(17, 16, 0);
        @(posedge clk);
        #1;
        chk("b2b_done_pulse", {31'd0, done}, 32'd0);

        // Asynchronous abort partway through an operation
        @(negedge clk);
        dividend = 16'd100;
        divisor  = 16'd7;
        start    = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        start = 1'b0;
        chk("pre_abort_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_q", {16'd0, quotient}, 32'd0);
        chk("abort_r", {16'd0, remainder}, 32'd0);
        chk("abort_dz", {31'd0, div_by_zero}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
            chk("no_done_after_abort", {31'd0, done}, 32'd0);
        end
        do_op(16'd50, 16'd6);

        for (int i = 0; i < 500; i++) begin
            logic [15:0] a;
            logic [15:0] b;
            a = 16'($urandom);
            if (i % 2 == 0) b = 16'($urandom_range(1, 255));
            else            b = 16'($urandom);
            if (b == 16'd0) b = 16'd1;
            do_op(a, b);
        end

        chk("sb_drained", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
